// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline definitions: opcode classes, MEM/WB FSM states and
// exception cause codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_IMM_LO = 6'h08;
  localparam logic [5:0] OP_IMM_HI = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  typedef enum logic {StIdle, StAccess} mem_state_e;

  typedef struct packed {
    logic       en;
    logic [4:0] dst;
  } wb_dest_t;

  // Register-file destination for non-memory opcodes.
  function automatic wb_dest_t wb_dest(logic [5:0] op, logic [4:0] rt, logic [4:0] rd);
    wb_dest_t d;
    d.en  = 1'b0;
    d.dst = 5'd0;
    if (op == OP_RTYPE) begin
      d.en  = 1'b1;
      d.dst = rd;
    end else if (op >= OP_IMM_LO && op <= OP_IMM_HI) begin
      d.en  = 1'b1;
      d.dst = rt;
    end else if (op == OP_JAL) begin
      d.en  = 1'b1;
      d.dst = 5'd31;
    end
    return d;
  endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// MIPS-32 memory-access / write-back stage with a req/ack data-memory port,
// pipeline stall generation and misalignment / timeout exceptions.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_out,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        write,
  output logic [4:0]  write_address,
  output logic [31:0] write_material,
  output logic        exc,
  output logic [1:0]  exc_cause
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  mem_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, wr_q, wr_d, exc_q, exc_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wr_data_q, wr_data_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [1:0]  cause_q, cause_d;

  logic     is_mem, aligned, timeout;
  wb_dest_t dest;

  always_comb begin
    is_mem  = in_valid && (opcode == OP_LW || opcode == OP_SW);
    aligned = (alu_out[1:0] == 2'b00);
    timeout = (cnt_q == CntMax);
    dest    = wb_dest(opcode, rt, rd);

    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    exc_d     = 1'b0;
    cause_d   = cause_q;
    stall     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          if (aligned) begin
            stall     = 1'b1;
            req_d     = 1'b1;
            we_d      = (opcode == OP_SW);
            addr_d    = alu_out;
            wdata_d   = rt_data;
            wr_addr_d = rt;
            cnt_d     = '0;
            state_d   = StAccess;
          end else begin
            exc_d   = 1'b1;
            cause_d = EXC_MISALIGN;
          end
        end else if (in_valid) begin
          wr_d      = dest.en && (dest.dst != 5'd0);
          wr_addr_d = dest.dst;
          wr_data_d = alu_out;
        end
      end
      StAccess: begin
        // Releasing stall on ack lets upstream advance on the same edge we retire.
        stall = !(dmem_ack || timeout);
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
          if (!we_q) begin
            wr_d      = (wr_addr_q != 5'd0);
            wr_data_d = dmem_rdata;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          exc_d   = 1'b1;
          cause_d = EXC_TIMEOUT;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      exc_q     <= 1'b0;
      cause_q   <= EXC_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign write          = wr_q;
  assign write_address  = wr_addr_q;
  assign write_material = wr_data_q;
  assign exc            = exc_q;
  assign exc_cause      = cause_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-cycle ALU/JAL write-backs
// plus hand-written load/store, misalignment, timeout and reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [4:0]  rt, rd;
  logic [31:0] rt_data, alu_out;
  logic        stall, dmem_req, dmem_we, dmem_ack, write, exc;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, write_material;
  logic [4:0]  write_address;
  logic [1:0]  exc_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .opcode        (opcode),
    .rt            (rt),
    .rd            (rd),
    .rt_data       (rt_data),
    .alu_out       (alu_out),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .write         (write),
    .write_address (write_address),
    .write_material(write_material),
    .exc           (exc),
    .exc_cause     (exc_cause)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_write;
    logic [4:0]  exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] wd, input logic [31:0] a);
    in_valid = v;
    opcode   = op;
    rt       = t;
    rd       = d;
    rt_data  = wd;
    alu_out  = a;
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'h08, 5'd5,  5'd0,  32'h0000_1234, 1'b1, 5'd5};   // ADDI
    vecs[1] = '{1'b1, 6'h00, 5'd9,  5'd3,  32'hAAAA_5555, 1'b1, 5'd3};   // R-type
    vecs[2] = '{1'b1, 6'h00, 5'd9,  5'd0,  32'h1111_1111, 1'b0, 5'd0};   // R-type rd=0
    vecs[3] = '{1'b1, 6'h03, 5'd2,  5'd4,  32'h0000_0400, 1'b1, 5'd31};  // JAL
    vecs[4] = '{1'b1, 6'h0D, 5'd0,  5'd6,  32'h2222_2222, 1'b0, 5'd0};   // ORI rt=0
    vecs[5] = '{1'b1, 6'h0F, 5'd12, 5'd1,  32'h5A5A_0000, 1'b1, 5'd12};  // LUI
    vecs[6] = '{1'b1, 6'h04, 5'd8,  5'd8,  32'h3333_3333, 1'b0, 5'd0};   // BEQ
    vecs[7] = '{1'b0, 6'h08, 5'd7,  5'd0,  32'h4444_4444, 1'b0, 5'd0};   // not valid

    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 6'h00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_exc", 32'(exc), 0);
    chk("rst_cause", 32'(exc_cause), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_waddr", 32'(write_address), 0);
    chk("rst_wmat", write_material, 0);
    chk("rst_stall", 32'(stall), 0);
    rst_n = 1'b1;

    // Back-to-back non-memory vectors, one per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].rt, vecs[i].rd, 32'h0, vecs[i].alu);
      #1 chk($sformatf("vec%0d_stall", i), 32'(stall), 0);
      tick();
      chk($sformatf("vec%0d_write", i), 32'(write), 32'(vecs[i].exp_write));
      if (vecs[i].exp_write) begin
        chk($sformatf("vec%0d_waddr", i), 32'(write_address), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_wmat", i), write_material, vecs[i].alu);
      end
    end

    // LW with ack two cycles after request rises: stall for three cycles.
    drive(1'b1, 6'h23, 5'd7, 5'd0, 32'h0, 32'h0000_0100);
    #1 chk("lw_stall0", 32'(stall), 1);
    tick();
    chk("lw_req", 32'(dmem_req), 1);
    chk("lw_we", 32'(dmem_we), 0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_stall1", 32'(stall), 1);
    chk("lw_nowrite", 32'(write), 0);
    tick();
    chk("lw_stall2", 32'(stall), 1);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("lw_stall_ack", 32'(stall), 0);
    tick();
    dmem_ack = 1'b0;
    in_valid = 1'b0;
    chk("lw_req_drop", 32'(dmem_req), 0);
    chk("lw_write", 32'(write), 1);
    chk("lw_waddr", 32'(write_address), 7);
    chk("lw_wmat", write_material, 32'hDEAD_BEEF);
    tick();
    chk("lw_write_pulse", 32'(write), 0);

    // SW acked in the first ACCESS cycle.
    drive(1'b1, 6'h2B, 5'd9, 5'd0, 32'hCAFE_F00D, 32'h0000_0200);
    #1 chk("sw_stall0", 32'(stall), 1);
    tick();
    chk("sw_req", 32'(dmem_req), 1);
    chk("sw_we", 32'(dmem_we), 1);
    chk("sw_addr", dmem_addr, 32'h200);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    dmem_ack = 1'b1;
    #1 chk("sw_stall_ack", 32'(stall), 0);
    tick();
    dmem_ack = 1'b0;
    in_valid = 1'b0;
    chk("sw_req_drop", 32'(dmem_req), 0);
    chk("sw_nowrite", 32'(write), 0);
    chk("sw_noexc", 32'(exc), 0);

    // Misaligned LW.
    drive(1'b1, 6'h23, 5'd7, 5'd0, 32'h0, 32'h0000_0102);
    #1 chk("mis_stall", 32'(stall), 0);
    tick();
    in_valid = 1'b0;
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_exc", 32'(exc), 1);
    chk("mis_cause", 32'(exc_cause), 1);
    chk("mis_write", 32'(write), 0);
    tick();
    chk("mis_exc_pulse", 32'(exc), 0);

    // Timeout with TIMEOUT=4: stall drops in the fourth ACCESS cycle.
    drive(1'b1, 6'h23, 5'd6, 5'd0, 32'h0, 32'h0000_0300);
    tick();
    chk("to_stall_a1", 32'(stall), 1);
    tick();
    chk("to_stall_a2", 32'(stall), 1);
    tick();
    chk("to_stall_a3", 32'(stall), 1);
    tick();
    chk("to_stall_a4", 32'(stall), 0);
    chk("to_req_a4", 32'(dmem_req), 1);
    in_valid = 1'b0;
    tick();
    chk("to_req_drop", 32'(dmem_req), 0);
    chk("to_exc", 32'(exc), 1);
    chk("to_cause", 32'(exc_cause), 2);
    chk("to_write", 32'(write), 0);
    tick();
    chk("to_exc_pulse", 32'(exc), 0);

    // Ack coinciding with the timeout cycle: ack wins.
    drive(1'b1, 6'h23, 5'd4, 5'd0, 32'h0, 32'h0000_0400);
    tick();
    tick();
    tick();
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0000_0055;
    tick();
    dmem_ack = 1'b0;
    in_valid = 1'b0;
    chk("race_exc", 32'(exc), 0);
    chk("race_write", 32'(write), 1);
    chk("race_wmat", write_material, 32'h55);

    // Reset in the middle of an access, then prove the FSM is back in IDLE.
    drive(1'b1, 6'h23, 5'd3, 5'd0, 32'h0, 32'h0000_0500);
    tick();
    chk("mrst_req_before", 32'(dmem_req), 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_req", 32'(dmem_req), 0);
    chk("mrst_stall", 32'(stall), 0);
    drive(1'b1, 6'h08, 5'd10, 5'd0, 32'h0, 32'h0000_0ABC);
    tick();
    in_valid = 1'b0;
    chk("mrst_idle_write", 32'(write), 1);
    chk("mrst_idle_wmat", write_material, 32'hABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
